// File: rtl/minmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : minmax_stream
// Brief    : Streaming windowed min/max with first-occurrence indices,
//            valid/ready on both the sample and result sides.
// Revision : 1.0 - initial release
// ============================================================================
module minmax_stream #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4,
  parameter bit SIGNED = 1'b1,
  localparam int IDXW  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] smallest,
  output logic [WIDTH-1:0] largest,
  output logic [IDXW-1:0]  min_idx,
  output logic [IDXW-1:0]  max_idx,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clear
);

  localparam logic [0:0]      c_st_acc  = 1'b0;
  localparam logic [0:0]      c_st_done = 1'b1;
  localparam logic [IDXW-1:0] c_last    = IDXW'(WINDOW - 1);

  logic [0:0]       r_state;
  logic [IDXW-1:0]  r_count;
  logic [WIDTH-1:0] r_run_min;
  logic [WIDTH-1:0] r_run_max;
  logic [IDXW-1:0]  r_run_min_idx;
  logic [IDXW-1:0]  r_run_max_idx;
  logic [WIDTH-1:0] r_smallest;
  logic [WIDTH-1:0] r_largest;
  logic [IDXW-1:0]  r_min_idx;
  logic [IDXW-1:0]  r_max_idx;

  logic             w_lt;
  logic             w_gt;
  logic             w_first;
  logic [WIDTH-1:0] w_next_min;
  logic [WIDTH-1:0] w_next_max;
  logic [IDXW-1:0]  w_next_min_idx;
  logic [IDXW-1:0]  w_next_max_idx;

  generate
    if (SIGNED) begin : g_signed_cmp
      assign w_lt = $signed(in_data) < $signed(r_run_min);
      assign w_gt = $signed(in_data) > $signed(r_run_max);
    end else begin : g_unsigned_cmp
      assign w_lt = in_data < r_run_min;
      assign w_gt = in_data > r_run_max;
    end
  endgenerate

  // Strict compares keep the earlier sample on ties; the first sample seeds both.
  assign w_first        = (r_count == '0);
  assign w_next_min     = (w_first || w_lt) ? in_data : r_run_min;
  assign w_next_max     = (w_first || w_gt) ? in_data : r_run_max;
  assign w_next_min_idx = w_first ? '0 : (w_lt ? r_count : r_run_min_idx);
  assign w_next_max_idx = w_first ? '0 : (w_gt ? r_count : r_run_max_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_st_acc;
      r_count       <= '0;
      r_run_min     <= '0;
      r_run_max     <= '0;
      r_run_min_idx <= '0;
      r_run_max_idx <= '0;
      r_smallest    <= '0;
      r_largest     <= '0;
      r_min_idx     <= '0;
      r_max_idx     <= '0;
    end else if (r_state == c_st_acc) begin
      if (clear) begin
        r_count <= '0;
      end else if (in_valid) begin
        r_run_min     <= w_next_min;
        r_run_max     <= w_next_max;
        r_run_min_idx <= w_next_min_idx;
        r_run_max_idx <= w_next_max_idx;
        if (r_count == c_last) begin
          r_count    <= '0;
          r_state    <= c_st_done;
          r_smallest <= w_next_min;
          r_largest  <= w_next_max;
          r_min_idx  <= w_next_min_idx;
          r_max_idx  <= w_next_max_idx;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end else if (out_ready) begin
      r_state <= c_st_acc;
    end
  end

  // Handshake flags decode the state register only, so no input-to-output path.
  assign in_ready  = (r_state == c_st_acc);
  assign out_valid = (r_state == c_st_done);
  assign smallest  = r_smallest;
  assign largest   = r_largest;
  assign min_idx   = r_min_idx;
  assign max_idx   = r_max_idx;

endmodule
`default_nettype wire

// File: tb/tb_minmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_minmax_stream
// Brief    : Directed bench for minmax_stream, signed and unsigned instances
//            side by side against a window-scanning reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minmax_stream;

  localparam int WIDTH  = 8;
  localparam int WINDOW = 4;
  localparam int IDXW   = $clog2(WINDOW);

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             out_ready;
  logic             clear;

  logic             in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [WIDTH-1:0] smallest_s, largest_s, smallest_u, largest_u;
  logic [IDXW-1:0]  min_idx_s, max_idx_s, min_idx_u, max_idx_u;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  minmax_stream #(.WIDTH(WIDTH), .WINDOW(WINDOW), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .smallest(smallest_s), .largest(largest_s),
    .min_idx(min_idx_s), .max_idx(max_idx_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .clear(clear)
  );

  minmax_stream #(.WIDTH(WIDTH), .WINDOW(WINDOW), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_u), .smallest(smallest_u), .largest(largest_u),
    .min_idx(min_idx_u), .max_idx(max_idx_u), .out_valid(out_valid_u),
    .out_ready(out_ready), .clear(clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect whole windows, then scan for first-occurrence extremes.
  logic [WIDTH-1:0] m_win [WINDOW];
  int               m_n;
  bit               m_done;
  logic [WIDTH-1:0] es_min, es_max, eu_min, eu_max;
  int               es_mini, es_maxi, eu_mini, eu_maxi;

  function automatic int key(input logic [WIDTH-1:0] v, input bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  task automatic scan(input bit sgn, output logic [WIDTH-1:0] mn, output logic [WIDTH-1:0] mx,
                      output int mni, output int mxi);
    mn = m_win[0]; mx = m_win[0]; mni = 0; mxi = 0;
    for (int i = 1; i < WINDOW; i++) begin
      if (key(m_win[i], sgn) < key(mn, sgn)) begin mn = m_win[i]; mni = i; end
      if (key(m_win[i], sgn) > key(mx, sgn)) begin mx = m_win[i]; mxi = i; end
    end
  endtask

  initial begin
    m_n = 0; m_done = 0;
    es_min = '0; es_max = '0; eu_min = '0; eu_max = '0;
    es_mini = 0; es_maxi = 0; eu_mini = 0; eu_maxi = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_n = 0; m_done = 0;
        es_min = '0; es_max = '0; eu_min = '0; eu_max = '0;
        es_mini = 0; es_maxi = 0; eu_mini = 0; eu_maxi = 0;
      end else if (!m_done) begin
        if (clear) m_n = 0;
        else if (in_valid) begin
          m_win[m_n] = in_data;
          m_n++;
          if (m_n == WINDOW) begin
            scan(1'b1, es_min, es_max, es_mini, es_maxi);
            scan(1'b0, eu_min, eu_max, eu_mini, eu_maxi);
            m_done = 1;
            m_n = 0;
          end
        end
      end else if (out_ready) begin
        m_done = 0;
      end
    end
  end

  // Every-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("s_in_ready",  32'(in_ready_s),  32'(!m_done));
        chk("s_out_valid", 32'(out_valid_s), 32'(m_done));
        chk("s_smallest",  32'(smallest_s),  32'(es_min));
        chk("s_largest",   32'(largest_s),   32'(es_max));
        chk("s_min_idx",   32'(min_idx_s),   32'(es_mini));
        chk("s_max_idx",   32'(max_idx_s),   32'(es_maxi));
        chk("u_in_ready",  32'(in_ready_u),  32'(!m_done));
        chk("u_out_valid", 32'(out_valid_u), 32'(m_done));
        chk("u_smallest",  32'(smallest_u),  32'(eu_min));
        chk("u_largest",   32'(largest_u),   32'(eu_max));
        chk("u_min_idx",   32'(min_idx_u),   32'(eu_mini));
        chk("u_max_idx",   32'(max_idx_u),   32'(eu_maxi));
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid_s), 32'd0);
    chk("consume_in_ready",  32'(in_ready_s),  32'd1);
  endtask

  task automatic lit_s(input string tag, input logic [WIDTH-1:0] mn, input int mni,
                       input logic [WIDTH-1:0] mx, input int mxi);
    chk({tag, "_valid"}, 32'(out_valid_s), 32'd1);
    chk({tag, "_min"},   32'(smallest_s),  32'(mn));
    chk({tag, "_mini"},  32'(min_idx_s),   32'(mni));
    chk({tag, "_max"},   32'(largest_s),   32'(mx));
    chk({tag, "_maxi"},  32'(max_idx_s),   32'(mxi));
  endtask

  task automatic lit_u(input string tag, input logic [WIDTH-1:0] mn, input int mni,
                       input logic [WIDTH-1:0] mx, input int mxi);
    chk({tag, "_valid"}, 32'(out_valid_u), 32'd1);
    chk({tag, "_min"},   32'(smallest_u),  32'(mn));
    chk({tag, "_mini"},  32'(min_idx_u),   32'(mni));
    chk({tag, "_max"},   32'(largest_u),   32'(mx));
    chk({tag, "_maxi"},  32'(max_idx_u),   32'(mxi));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1;
    chk("rst_in_ready",  32'(in_ready_s),  32'd1);
    chk("rst_out_valid", 32'(out_valid_s), 32'd0);
    chk("rst_smallest",  32'(smallest_s),  32'd0);
    chk("rst_largest",   32'(largest_u),   32'd0);
    reset = 1'b0;

    // Signed extremes; result must be visible right after the 4th accept.
    push4(8'd5, 8'hFD, 8'd127, 8'h80);
    lit_s("ext_s", 8'h80, 3, 8'h7F, 2);
    lit_u("ext_u", 8'h05, 0, 8'hFD, 1);
    consume();

    push4(8'd7, 8'd7, 8'd7, 8'd7);
    lit_s("tie7", 8'd7, 0, 8'd7, 0);
    consume();

    push4(8'd2, 8'd9, 8'd2, 8'd9);
    lit_s("tie29", 8'd2, 0, 8'd9, 1);
    consume();

    push4(8'h80, 8'h01, 8'hFF, 8'h00);
    lit_u("mode_u", 8'h00, 3, 8'hFF, 2);
    lit_s("mode_s", 8'h80, 0, 8'h01, 1);

    // Backpressure with samples offered that must not be taken.
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("bp_in_ready", 32'(in_ready_s), 32'd0);
    lit_u("bp_u", 8'h00, 3, 8'hFF, 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready_s), 32'd1);
    push4(8'd9, 8'd3, 8'd9, 8'd3);
    lit_s("after_bp", 8'd3, 1, 8'd9, 0);
    consume();

    // Reset mid-window.
    push(8'd11); push(8'd22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_smallest", 32'(smallest_s), 32'd0);
    chk("mid_rst_max_idx",  32'(max_idx_s),  32'd0);
    push4(8'd1, 8'd2, 8'd3, 8'd4);
    lit_s("post_rst", 8'd1, 0, 8'd4, 3);
    consume();

    // Clear after three samples, with a same-cycle sample that must be dropped.
    push(8'd4); push(8'd6); push(8'd8);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_no_result", 32'(out_valid_s), 32'd0);
    push4(8'd10, 8'hFF, 8'd3, 8'd3);
    lit_s("clr_s", 8'hFF, 1, 8'd10, 0);
    lit_u("clr_u", 8'h03, 2, 8'hFF, 1);

    // Clear while holding a result is ignored.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    lit_s("clr_done", 8'hFF, 1, 8'd10, 0);
    consume();

    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minmax_stream.md
Name: minmax_stream

Overview:
- Parametrised streaming min/max unit; generalises the fixed 4-input signed 8-bit comparator to windows of WINDOW samples of WIDTH bits, in signed or unsigned mode.
- Accepts one sample per cycle over a valid/ready handshake. Tracks the running smallest and largest values and the index of each.
- Presents the result over a second valid/ready handshake.
- Sits between a sample source (ADC/switch sampler) and display/compare logic.

Parameters:
- WIDTH, 8, sample width in bits (>=2).
- WINDOW, 4, samples per result (>=2).
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.
- IDXW, $clog2(WINDOW), index/counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  sample.
- in_valid  in  1  sample present.
- in_ready  out  1  unit can accept a sample.
- smallest  out  WIDTH  minimum of the completed window.
- largest  out  WIDTH  maximum of the completed window.
- min_idx  out  IDXW  window position (0-based) of smallest.
- max_idx  out  IDXW  window position (0-based) of largest.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- clear  in  1  synchronous abort of the current window (no result produced).

Behaviour:
- Reset (reset=1 at clk edge):
  - state=ACC, count=0, out_valid=0, in_ready=1.
  - smallest=0, largest=0, min_idx=0, max_idx=0.
  - Reset overrides clear and both handshakes. Reset mid-window discards all partial state.
- States: ACC (collecting), DONE (holding result).
- Transfer: a sample is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- ACC:
  - in_ready=1, out_valid=0.
  - Accepted sample with count==0: load the sample into both running min and running max, both indices=0.
  - Accepted sample with count>0: replace running min only if sample < min (strict); replace running max only if sample > max (strict); the index of a replaced value becomes count.
  - Ties keep the earlier value, so the lowest index wins.
  - count increments per accepted sample.
  - On the accept with count==WINDOW-1: next cycle state=DONE, out_valid=1, outputs carry the final min/max/indices, count=0.
  - Latency: result is visible the cycle after the last sample is accepted.
- DONE:
  - in_ready=0, out_valid=1. Outputs are held stable until consumed.
  - On out_ready=1: next cycle state=ACC, out_valid=0, in_ready=1. No sample is accepted in the consume cycle.
- Compare mode:
  - SIGNED=1: both operands compared as signed.
  - SIGNED=0: both operands compared as unsigned.
  - Selected at elaboration; no mixed-sign compares.
- clear:
  - In ACC: count=0 next cycle; any sample accepted in the same cycle is discarded; output registers are unchanged.
  - In DONE: ignored; the result must be consumed first.
- Output registers change only when entering DONE. After consume they keep the last result, but out_valid=0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Value extremes:
  - SIGNED=1: most negative (-2^(WIDTH-1)) and most positive (2^(WIDTH-1)-1) values must compare correctly.
  - SIGNED=0: 0 and 2^WIDTH-1 must compare correctly.
- Window wrap: IDXW is sized so that count==WINDOW-1 is representable. When WINDOW is not a power of two, count never exceeds WINDOW-1.

Test Plan:
- WIDTH=8, WINDOW=4, SIGNED=1: samples 5, -3, 127, -128 back-to-back -> out_valid one cycle after the 4th accept; smallest=-128 (0x80), min_idx=3, largest=127, max_idx=2.
- Ties: samples 7, 7, 7, 7 -> smallest=largest=7, min_idx=max_idx=0. Samples 2, 9, 2, 9 -> min_idx=0, max_idx=1.
- SIGNED=0: samples 0x80, 0x01, 0xFF, 0x00 -> smallest=0x00, min_idx=3, largest=0xFF, max_idx=2. The same stream with SIGNED=1 gives smallest=0x80 (idx 0), largest=0x01 (idx 1).
- Backpressure: hold out_ready=0 for 5 cycles after the result -> outputs stable, in_ready=0, extra in_valid samples not accepted. Raise out_ready -> in_ready=1 next cycle, and the next window starts at index 0.
- Reset mid-window after 2 samples -> all outputs 0, count restarts. Four new samples 1, 2, 3, 4 -> smallest=1, idx 0; largest=4, idx 3.
- clear after 3 samples (4, 6, 8), then samples 10, -1, 3, 3 -> smallest=-1, idx 1; largest=10, idx 0. No result is emitted for the aborted window.
